// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: receive control for the UART RX path. Synchronizes the line,
// detects the start edge, steps the bit timers through one packet and strobes
// the receive buffer. Optional RX_TIMEOUT_EN adds a RECV-state watchdog.
module uart_rx_ctrl #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic serial_in,
  input  logic packet_done,
  input  logic stop_bit,
  output logic timer_clear,
  output logic timer_enable,
  output logic sbc_enable,
  output logic load_buffer,
  output logic framing_error,
  output logic rx_busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    RECV    = 3'd2,
    STOPCHK = 3'd3,
    LOAD    = 3'd4
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   line_prev;
  logic                   line_sync;
  logic                   start_det;

  assign line_sync = sync_q[SYNC_STAGES-1];
  // A 1->0 transition of the synchronized line; only acted on in IDLE.
  assign start_det = line_prev & ~line_sync;

  // Line synchronizer plus edge history; all flops reset to the idle-high level
  // so leaving reset can never look like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= '1;
      line_prev <= 1'b1;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], serial_in};
      line_prev <= line_sync;
    end
  end

`ifdef RX_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0] wd_cnt;
`endif

  // Packet sequencer; outputs are registered alongside the state so each one
  // is a pure decode of the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      timer_clear   <= 1'b0;
      timer_enable  <= 1'b0;
      sbc_enable    <= 1'b0;
      load_buffer   <= 1'b0;
      framing_error <= 1'b0;
      rx_busy       <= 1'b0;
`ifdef RX_TIMEOUT_EN
      wd_cnt        <= '0;
`endif
    end else begin
      timer_clear  <= 1'b0;
      timer_enable <= 1'b0;
      sbc_enable   <= 1'b0;
      load_buffer  <= 1'b0;
      rx_busy      <= 1'b1;
      case (state)
        IDLE: begin
          if (start_det) begin
            state         <= CLEAR;
            timer_clear   <= 1'b1;
            framing_error <= 1'b0;
          end else begin
            rx_busy <= 1'b0;
          end
        end
        CLEAR: begin
          state        <= RECV;
          timer_enable <= 1'b1;
`ifdef RX_TIMEOUT_EN
          wd_cnt       <= '0;
`endif
        end
        RECV: begin
          // packet_done wins over a watchdog expiry in the same cycle.
          if (packet_done) begin
            state      <= STOPCHK;
            sbc_enable <= 1'b1;
`ifdef RX_TIMEOUT_EN
          end else if (wd_cnt == WD_LAST) begin
            state         <= IDLE;
            framing_error <= 1'b1;
            rx_busy       <= 1'b0;
`endif
          end else begin
            timer_enable <= 1'b1;
`ifdef RX_TIMEOUT_EN
            wd_cnt       <= wd_cnt + 1'b1;
`endif
          end
        end
        STOPCHK: begin
          if (!stop_bit) begin
            state         <= IDLE;
            framing_error <= 1'b1;
            rx_busy       <= 1'b0;
          end else begin
            state       <= LOAD;
            load_buffer <= 1'b1;
          end
        end
        LOAD: begin
          state   <= IDLE;
          rx_busy <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed packets push expected transaction records;
// a negedge monitor rebuilds each transaction from the outputs and compares.
module tb_uart_rx_ctrl;

  localparam int TO = 50;
`ifdef RX_TIMEOUT_EN
  localparam int LEN = 40;
`else
  localparam int LEN = 80;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic serial_in = 1'b1;
  logic packet_done = 1'b0;
  logic stop_bit = 1'b1;
  logic timer_clear, timer_enable, sbc_enable, load_buffer, framing_error, rx_busy;

  uart_rx_ctrl #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .serial_in(serial_in), .packet_done(packet_done),
    .stop_bit(stop_bit), .timer_clear(timer_clear), .timer_enable(timer_enable),
    .sbc_enable(sbc_enable), .load_buffer(load_buffer),
    .framing_error(framing_error), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int clr;     // cycle timer_clear is seen
    int en;      // number of timer_enable cycles
    int ld;      // number of load_buffer pulses
    int ld_cyc;  // cycle of the load pulse
    int ferr;    // framing_error once back in IDLE
    int endc;    // first IDLE cycle
  } exp_t;
  exp_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_timer_clear"}, timer_clear, 0);
    chk({tag, "_timer_enable"}, timer_enable, 0);
    chk({tag, "_sbc_enable"}, sbc_enable, 0);
    chk({tag, "_load_buffer"}, load_buffer, 0);
    chk({tag, "_framing_error"}, framing_error, 0);
    chk({tag, "_rx_busy"}, rx_busy, 0);
  endtask

  // Monitor: rebuild each transaction and score it when rx_busy drops.
  int m_clr = -1, m_en = 0, m_ld = 0, m_ldc = -1;
  logic m_cferr = 1'b0;
  logic prev_busy = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (timer_clear) begin
      m_clr = cyc; m_en = 0; m_ld = 0; m_ldc = -1; m_cferr = framing_error;
    end
    if (timer_enable) m_en++;
    if (load_buffer) begin m_ld++; m_ldc = cyc; end
    if (prev_busy && !rx_busy) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_end: transaction ended at cycle %0d, expected none", cyc);
      end else begin
        e = q.pop_front();
        chk("clear_cycle", m_clr, e.clr);
        chk("clear_ferr", m_cferr, 0);
        chk("enable_cycles", m_en, e.en);
        chk("load_count", m_ld, e.ld);
        if (e.ld != 0) chk("load_cycle", m_ldc, e.ld_cyc);
        chk("end_ferr", framing_error, e.ferr);
        chk("end_cycle", cyc, e.endc);
      end
    end
    prev_busy = rx_busy;
  end

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // mode 0: plain, 1: line glitch during RECV, 2: line edge coincident with packet_done
  task automatic send_packet(input int len, input bit stop, input int mode);
    int s, c, n;
    exp_t e;
    s = cyc; c = s + 3; n = c + len;
    e.clr = c; e.en = len; e.ld = stop ? 1 : 0; e.ld_cyc = n + 2;
    e.ferr = stop ? 0 : 1; e.endc = stop ? n + 3 : n + 2;
    q.push_back(e);
    serial_in = 1'b0;
    wait_until(s + 5); serial_in = 1'b1;
    if (mode == 1) begin
      wait_until(c + 20); serial_in = 1'b0;
      wait_until(c + 24); serial_in = 1'b1;
    end
    if (mode == 2) begin
      wait_until(n - 2); serial_in = 1'b0;
    end
    wait_until(n); packet_done = 1'b1; stop_bit = stop;
    wait_until(n + 1); packet_done = 1'b0;
  endtask

  task automatic send_timeout();
    int s, c;
    exp_t e;
    s = cyc; c = s + 3;
    e.clr = c; e.en = TO; e.ld = 0; e.ld_cyc = -1; e.ferr = 1; e.endc = c + TO + 1;
    q.push_back(e);
    serial_in = 1'b0;
    wait_until(s + 5); serial_in = 1'b1;
    wait_until(c + TO + 2);
  endtask

  task automatic reset_mid_recv();
    int s, c;
    exp_t e;
    s = cyc; c = s + 3;
    e.clr = c; e.en = 30; e.ld = 0; e.ld_cyc = -1; e.ferr = 0; e.endc = c + 31;
    q.push_back(e);
    serial_in = 1'b0;
    wait_until(s + 5); serial_in = 1'b1;
    wait_until(c + 30);
    #2 rst = 1'b1;
    #1 chk_all_zero("rst_mid");
    wait_until(c + 33); rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("post_rst_busy", rx_busy, 0);
    chk("post_rst_clear", timer_clear, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_all_zero("in_reset");
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk_all_zero("idle");

    // packet_done in IDLE must not start anything
    packet_done = 1'b1; @(negedge clk); packet_done = 1'b0;
    repeat (5) @(negedge clk);
    chk("spurious_pd_busy", rx_busy, 0);

    send_packet(LEN, 1'b1, 1);
    repeat (10) @(negedge clk);

    send_packet(LEN, 1'b0, 0);
    repeat (10) @(negedge clk);
    chk("ferr_held", framing_error, 1);

    // back-to-back: second start lands on the single IDLE cycle
    send_packet(LEN, 1'b1, 0);
    send_packet(20, 1'b1, 0);
    repeat (10) @(negedge clk);

    // coincident edge is discarded; a line held low does not retrigger
    send_packet(LEN, 1'b1, 2);
    repeat (10) @(negedge clk);
    chk("low_line_busy", rx_busy, 0);
    serial_in = 1'b1;
    repeat (10) @(negedge clk);
    chk("line_rise_busy", rx_busy, 0);

    reset_mid_recv();

`ifdef RX_TIMEOUT_EN
    send_timeout();
    repeat (10) @(negedge clk);
    send_packet(TO, 1'b1, 0);
    repeat (10) @(negedge clk);
`endif

    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    chk("queue_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
